arcade_key_input: RTL

Input-conditioning stage directly upstream of the game core's `in0_reg`/`in1_reg` inputs and the 4-way joystick filters. It decodes PS/2 key events and MiSTer joystick words into registered per-player button levels, and turns coin requests into fixed-width, rate-limited coin pulses that the core's coin counter accepts reliably. All outputs are active-high; the top level inverts them when packing the core input registers.

---
 rtl/arcade_key_input.sv | 297 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/arcade_key_input.sv
// ---------------------------------------------------------------------------
// arcade_key_input
//
// Input-conditioning stage in front of the game core's input registers.
// Decodes PS/2 key events and MiSTer joystick words into registered,
// active-high per-player button levels. It also turns coin key presses into
// fixed-width, rate-limited coin pulses.
//
// Parameters
//   COIN_CYCLES  coin pulse width, and also the minimum low gap after each
//                pulse, in clk_sys cycles (2 .. 2^24-1)
//
// Compile-time option
//   AUTO_COIN_EN  when defined, a rising edge of start1 or start2 also
//                 requests a coin1 pulse (one-button start).
//
// Ports
//   clk_sys     in   system clock
//   reset_n     in   asynchronous active-low reset
//   ps2_key     in   [10] event toggle, [9] pressed, [8] extended, [7:0] code
//   joystick_0  in   player 1 pad: [0] right [1] left [2] down [3] up
//                    [4] start1 [5] start2
//   joystick_1  in   player 2 pad, same layout
//   p1_dir      out  {up, down, left, right}, player 1
//   p2_dir      out  {up, down, left, right}, player 2
//   fire1/2     out  fire buttons
//   start1/2    out  start buttons
//   cheat       out  rack-advance key
//   coin1/2     out  shaped coin pulses
//
// Coin FSM handshake: a request is a single-cycle strobe. It is accepted
// in IDLE. In PULSE or GAP it is held in a one-deep pending flag. A request
// that arrives while pending is already set is dropped.
// ---------------------------------------------------------------------------

module arcade_coin_shaper #(
    parameter int COIN_CYCLES = 2400000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic req,
    output logic coin
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [23:0] RELOAD = 24'(COIN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic        coin_q, coin_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        coin_d    = coin_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = PULSE;
                    cnt_d   = RELOAD;
                    coin_d  = 1'b1;
                end
            end
            PULSE: begin
                // A request on the PULSE->GAP cycle still becomes pending.
                if (req) pending_d = 1'b1;
                if (cnt_q == 24'd0) begin
                    state_d = GAP;
                    cnt_d   = RELOAD;
                    coin_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            GAP: begin
                if (req) pending_d = 1'b1;
                if (cnt_q == 24'd0) begin
                    if (pending_q || req) begin
                        // The pending request is consumed here. A fresh
                        // request is kept only if one was already waiting.
                        state_d   = PULSE;
                        cnt_d     = RELOAD;
                        coin_d    = 1'b1;
                        pending_d = pending_q & req;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                coin_d    = 1'b0;
                pending_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 24'd0;
            pending_q <= 1'b0;
            coin_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            coin_q    <= coin_d;
        end
    end

    assign coin = coin_q;
endmodule

module arcade_key_input #(
    parameter int COIN_CYCLES = 2400000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    output logic [3:0]  p1_dir,
    output logic [3:0]  p2_dir,
    output logic        fire1,
    output logic        fire2,
    output logic        start1,
    output logic        start2,
    output logic        cheat,
    output logic        coin1,
    output logic        coin2
);
    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic fire1;
        logic start1;
        logic start2;
        logic cheat;
        logic coin1;
        logic coin2;
        logic p2_up;
        logic p2_down;
        logic p2_left;
        logic p2_right;
        logic fire2;
    } keys_t;

    keys_t keys_q, keys_d;
    logic  toggle_q;
    // Cleared by reset, so the first clock after release only captures the
    // toggle and never produces an event.
    logic  armed_q;
    logic  key_evt;
    logic  key_pressed;
    logic  key_ext;
    logic  [7:0] key_code;

    logic [3:0] p1_dir_q, p1_dir_d;
    logic [3:0] p2_dir_q, p2_dir_d;
    logic       fire1_q, fire1_d;
    logic       fire2_q, fire2_d;
    logic       start1_q, start1_d;
    logic       start2_q, start2_d;
    logic       cheat_q, cheat_d;
    logic       coin1_key_prev_q, coin2_key_prev_q;
    logic       coin1_req, coin2_req;

    logic unused_joy_bits;
    assign unused_joy_bits = ^{joystick_0[15:6], joystick_1[15:6]};

    assign key_evt     = armed_q && (ps2_key[10] != toggle_q);
    assign key_pressed = ps2_key[9];
    assign key_ext     = ps2_key[8];
    assign key_code    = ps2_key[7:0];

    // Key latches: direction codes match with either value of ext. All
    // other codes are mapped only when ext = 0.
    always_comb begin
        keys_d = keys_q;
        if (key_evt) begin
            case (key_code)
                8'h75: keys_d.up    = key_pressed;
                8'h72: keys_d.down  = key_pressed;
                8'h6B: keys_d.left  = key_pressed;
                8'h74: keys_d.right = key_pressed;
                8'h29, 8'h14: if (!key_ext) keys_d.fire1    = key_pressed;
                8'h05, 8'h16: if (!key_ext) keys_d.start1   = key_pressed;
                8'h06, 8'h1E: if (!key_ext) keys_d.start2   = key_pressed;
                8'h03:        if (!key_ext) keys_d.cheat    = key_pressed;
                8'h2E:        if (!key_ext) keys_d.coin1    = key_pressed;
                8'h36:        if (!key_ext) keys_d.coin2    = key_pressed;
                8'h2D:        if (!key_ext) keys_d.p2_up    = key_pressed;
                8'h2B:        if (!key_ext) keys_d.p2_down  = key_pressed;
                8'h23:        if (!key_ext) keys_d.p2_left  = key_pressed;
                8'h34:        if (!key_ext) keys_d.p2_right = key_pressed;
                8'h1C:        if (!key_ext) keys_d.fire2    = key_pressed;
                default: ;
            endcase
        end
    end

    // Joystick bits [3:0] are already in {up, down, left, right} order.
    always_comb begin
        p1_dir_d = {keys_q.up, keys_q.down, keys_q.left, keys_q.right} | joystick_0[3:0];
        p2_dir_d = {keys_q.p2_up, keys_q.p2_down, keys_q.p2_left, keys_q.p2_right}
                   | joystick_1[3:0];
        fire1_d  = keys_q.fire1;
        fire2_d  = keys_q.fire2;
        start1_d = keys_q.start1 | joystick_0[4] | joystick_1[4];
        start2_d = keys_q.start2 | joystick_0[5] | joystick_1[5];
        cheat_d  = keys_q.cheat;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            keys_q           <= '0;
            toggle_q         <= 1'b0;
            armed_q          <= 1'b0;
            p1_dir_q         <= 4'd0;
            p2_dir_q         <= 4'd0;
            fire1_q          <= 1'b0;
            fire2_q          <= 1'b0;
            start1_q         <= 1'b0;
            start2_q         <= 1'b0;
            cheat_q          <= 1'b0;
            coin1_key_prev_q <= 1'b0;
            coin2_key_prev_q <= 1'b0;
        end else begin
            keys_q           <= keys_d;
            toggle_q         <= ps2_key[10];
            armed_q          <= 1'b1;
            p1_dir_q         <= p1_dir_d;
            p2_dir_q         <= p2_dir_d;
            fire1_q          <= fire1_d;
            fire2_q          <= fire2_d;
            start1_q         <= start1_d;
            start2_q         <= start2_d;
            cheat_q          <= cheat_d;
            coin1_key_prev_q <= keys_q.coin1;
            coin2_key_prev_q <= keys_q.coin2;
        end
    end

`ifdef AUTO_COIN_EN
    logic start1_prev_q, start2_prev_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            start1_prev_q <= 1'b0;
            start2_prev_q <= 1'b0;
        end else begin
            start1_prev_q <= start1_q;
            start2_prev_q <= start2_q;
        end
    end

    assign coin1_req = (keys_q.coin1 & ~coin1_key_prev_q)
                     | (start1_q & ~start1_prev_q)
                     | (start2_q & ~start2_prev_q);
`else
    assign coin1_req = keys_q.coin1 & ~coin1_key_prev_q;
`endif
    assign coin2_req = keys_q.coin2 & ~coin2_key_prev_q;

    arcade_coin_shaper #(.COIN_CYCLES(COIN_CYCLES)) u_coin1 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .req     (coin1_req),
        .coin    (coin1)
    );

    arcade_coin_shaper #(.COIN_CYCLES(COIN_CYCLES)) u_coin2 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .req     (coin2_req),
        .coin    (coin2)
    );

    assign p1_dir = p1_dir_q;
    assign p2_dir = p2_dir_q;
    assign fire1  = fire1_q;
    assign fire2  = fire2_q;
    assign start1 = start1_q;
    assign start2 = start2_q;
    assign cheat  = cheat_q;
endmodule
